// File: rtl/mux_sel_rr_arbiter_if.sv
// mux_sel_rr_arbiter_if: request/grant/select bundle between requesters and the mux-select arbiter
interface mux_sel_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;
  modport master(output req, input gnt, sel, busy, timeout);
  modport slave(input req, output gnt, sel, busy, timeout);
endinterface

// File: rtl/mux_sel_rr_arbiter.sv
// mux_sel_rr_arbiter: round-robin owner arbiter driving a shared 4:1 mux select; ARB_TIMEOUT_EN enables forced release after MAX_HOLD cycles
module mux_sel_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input logic                   clk,
  input logic                   rst_n,
  mux_sel_rr_arbiter_if.slave   bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  if (MAX_HOLD < 2 || (2 ** CNT_W) <= MAX_HOLD) begin : g_cfg_err
    $error("mux_sel_rr_arbiter: need MAX_HOLD >= 2 and 2**CNT_W > MAX_HOLD");
  end
  logic [0:0] state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] rot;
  logic [1:0] off;
  logic [1:0] pick;
  logic       expire;
`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             timeout_q, timeout_d;
  assign expire = state_q == BUSY && bus.req[sel_q] && hold_q == CNT_W'(MAX_HOLD - 1);
  // hold counter restarts on every grant and saturates while the owner keeps it
  always_comb begin
    hold_d    = state_q == IDLE ? '0 : (hold_q == {CNT_W{1'b1}} ? hold_q : hold_q + 1'b1);
    timeout_d = expire;
  end
  assign bus.timeout = timeout_q;
`else
  assign expire      = 1'b0;
  assign bus.timeout = 1'b0;
`endif
  // rotate requests so index 0 is the pointer, then take the first set bit
  always_comb begin
    for (int i = 0; i < 4; i++) rot[i] = bus.req[2'(ptr_q + 2'(i))];
    off  = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    pick = ptr_q + off;
  end
  // grant from IDLE, release from BUSY; sel only moves on a grant so the mux holds through the gap
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (state_q == IDLE && |bus.req) begin
      state_d = BUSY;
      gnt_d   = 4'b0001 << pick;
      sel_d   = pick;
    end else if (state_q == BUSY && (!bus.req[sel_q] || expire)) begin
      state_d = IDLE;
      gnt_d   = '0;
      ptr_d   = sel_q + 2'd1;
    end
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end
  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = |gnt_q;
endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// tb_mux_sel_rr_arbiter: directed scoreboard bench for the round-robin mux-select arbiter
module tb_mux_sel_rr_arbiter;
  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       to;
    string      name;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  logic [3:0] ins [4];
  logic [3:0] y;
  mux_sel_rr_arbiter_if bus();
  mux_sel_rr_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    ins[0] = 4'b0101;
    ins[1] = 4'b1111;
    ins[2] = 4'b0000;
    ins[3] = 4'b1010;
  end
  assign y = ins[bus.sel];
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask
  // one cycle of stimulus; the expected outputs after the next edge go to the scoreboard
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] g, input logic [1:0] s, input logic to, input string name);
    exp_t e;
    @(negedge clk);
    rst_n   = r;
    bus.req = rq;
    e.gnt = g;
    e.sel = s;
    e.to  = to;
    e.name = name;
    sb.push_back(e);
  endtask
  // monitor: pops one expectation per cycle and checks outputs plus invariants
  initial begin
    exp_t e;
    logic [1:0] idx;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.name, ".gnt"}, bus.gnt, e.gnt);
        chk({e.name, ".sel"}, {2'b00, bus.sel}, {2'b00, e.sel});
        chk({e.name, ".busy"}, {3'b000, bus.busy}, {3'b000, |e.gnt});
        chk({e.name, ".timeout"}, {3'b000, bus.timeout}, {3'b000, e.to});
        chk({e.name, ".y"}, y, ins[e.sel]);
      end
      chk("inv.onehot", {3'b000, $onehot0(bus.gnt)}, 4'b0001);
      chk("inv.busy", {3'b000, bus.busy}, {3'b000, |bus.gnt});
      if (bus.busy) begin
        idx = bus.gnt[1] ? 2'd1 : bus.gnt[2] ? 2'd2 : bus.gnt[3] ? 2'd3 : 2'd0;
        chk("inv.sel_idx", {2'b00, bus.sel}, {2'b00, idx});
      end
    end
  end
  initial begin
    bus.req = 4'b0000;
    step(0, 4'b1111, 4'b0000, 2'd0, 0, "rst0");
    step(0, 4'b1111, 4'b0000, 2'd0, 0, "rst1");
    step(1, 4'b1111, 4'b0001, 2'd0, 0, "rst_rel");
    step(1, 4'b1111, 4'b0001, 2'd0, 0, "rot0a");
    step(1, 4'b1111, 4'b0001, 2'd0, 0, "rot0b");
    step(1, 4'b1110, 4'b0000, 2'd0, 0, "rot0r");
    step(1, 4'b1111, 4'b0010, 2'd1, 0, "rot1");
    step(1, 4'b1111, 4'b0010, 2'd1, 0, "rot1a");
    step(1, 4'b1111, 4'b0010, 2'd1, 0, "rot1b");
    step(1, 4'b1101, 4'b0000, 2'd1, 0, "rot1r");
    step(1, 4'b1111, 4'b0100, 2'd2, 0, "rot2");
    step(1, 4'b1111, 4'b0100, 2'd2, 0, "rot2a");
    step(1, 4'b1111, 4'b0100, 2'd2, 0, "rot2b");
    step(1, 4'b1011, 4'b0000, 2'd2, 0, "rot2r");
    step(1, 4'b1111, 4'b1000, 2'd3, 0, "rot3");
    step(1, 4'b1111, 4'b1000, 2'd3, 0, "rot3a");
    step(1, 4'b1111, 4'b1000, 2'd3, 0, "rot3b");
    step(1, 4'b0111, 4'b0000, 2'd3, 0, "rot3r");
    step(1, 4'b1111, 4'b0001, 2'd0, 0, "rot0wrap");
    step(1, 4'b1110, 4'b0000, 2'd0, 0, "rot0wrap_r");
    step(1, 4'b0100, 4'b0100, 2'd2, 0, "wrap_own2");
    step(1, 4'b0000, 4'b0000, 2'd2, 0, "wrap_rel2");
    step(1, 4'b0101, 4'b0001, 2'd0, 0, "wrap_skip0");
    step(1, 4'b0100, 4'b0000, 2'd0, 0, "wrap_rel0");
    step(1, 4'b0101, 4'b0100, 2'd2, 0, "wrap_skip2");
    step(1, 4'b0000, 4'b0000, 2'd2, 0, "ign_rel2");
    step(1, 4'b0010, 4'b0010, 2'd1, 0, "ign_own1");
    step(1, 4'b1010, 4'b0010, 2'd1, 0, "ign_pulse3");
    step(1, 4'b0010, 4'b0010, 2'd1, 0, "ign_hold1");
    step(1, 4'b0000, 4'b0000, 2'd1, 0, "ign_rel1");
    step(1, 4'b0000, 4'b0000, 2'd1, 0, "ign_idle1");
    step(1, 4'b0000, 4'b0000, 2'd1, 0, "ign_idle2");
    step(1, 4'b1000, 4'b1000, 2'd3, 0, "dp_own3");
    step(1, 4'b1000, 4'b1000, 2'd3, 0, "dp_hold3");
    step(1, 4'b0000, 4'b0000, 2'd3, 0, "dp_gap");
    step(1, 4'b0000, 4'b0000, 2'd3, 0, "dp_idle");
    step(1, 4'b0100, 4'b0100, 2'd2, 0, "to_own2");
`ifdef ARB_TIMEOUT_EN
    step(1, 4'b0101, 4'b0100, 2'd2, 0, "to_h1");
    step(1, 4'b0101, 4'b0100, 2'd2, 0, "to_h2");
    step(1, 4'b0101, 4'b0100, 2'd2, 0, "to_h3");
    step(1, 4'b0101, 4'b0000, 2'd2, 1, "to_fire");
    step(1, 4'b0101, 4'b0001, 2'd0, 0, "to_next0");
`else
    for (int i = 0; i < 20; i++) step(1, 4'b0101, 4'b0100, 2'd2, 0, "to_unbounded");
`endif
    step(0, 4'b0101, 4'b0000, 2'd0, 0, "rst_mid");
    step(1, 4'b0101, 4'b0001, 2'd0, 0, "rst_mid_rel");
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
